enc512x9_pipe: RTL and testbench

- Inverse of the 9-to-512 address decoder: compresses a 512-bit request/select vector back into a 9-bit index.
- Priority encoder; the lowest set bit wins.
- Two-stage registered pipeline with valid/ready handshakes at both ends.
- Used where one-hot row/word selects or hit vectors are turned back into binary indices, e.g. writeback tag recovery and hit-index generation.

---
 rtl/enc512x9_pipe.sv | 125 ++++++++++++
 tb/tb_enc512x9_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/enc512x9_pipe.sv
// enc512x9_pipe: 512-to-9 lowest-set-bit priority encoder, two registered stages with valid/ready.
// Optional ONEHOT_CHECK_EN adds an out_multi flag for vectors with more than one bit set.

module enc512x9_grp #(
    parameter int GW = 64
) (
    input  logic [GW-1:0]         v,
    output logic                  any,
    output logic [$clog2(GW)-1:0] idx
);
    localparam int IW = $clog2(GW);

    assign any = |v;

    // Scan high to low so the lowest set bit is the last writer.
    always_comb begin
        idx = '0;
        for (int i = GW - 1; i >= 0; i--)
            if (v[i]) idx = IW'(i);
    end
endmodule

module enc512x9_pipe #(
    parameter int NGRP = 8,
    parameter int GW   = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NGRP*GW-1:0]             in_vec,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [$clog2(NGRP*GW)-1:0]     out_idx,
    output logic                           out_none,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_multi
);
    localparam int IW  = $clog2(GW);
    localparam int GSW = $clog2(NGRP);
    localparam int OW  = $clog2(NGRP * GW);

    logic [NGRP-1:0][GW-1:0] grp_vec;
    logic [NGRP-1:0]         grp_any;
    logic [NGRP-1:0][IW-1:0] grp_idx;

    logic                    s1_valid;
    logic [NGRP-1:0]         s1_any;
    logic [NGRP-1:0][IW-1:0] s1_idx;

    logic          in_xfer, out_xfer, s2_load;
    logic [OW-1:0] nxt_idx;
    logic          nxt_none;

    assign grp_vec = in_vec;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        enc512x9_grp #(.GW(GW)) u_grp (
            .v   (grp_vec[g]),
            .any (grp_any[g]),
            .idx (grp_idx[g])
        );
    end

    // s1 may refill on the same edge it drains into s2.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_any   <= '0;
            s1_idx   <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_any   <= grp_any;
            s1_idx   <= grp_idx;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_comb begin
        nxt_none = ~|s1_any;
        nxt_idx  = '0;
        for (int g = NGRP - 1; g >= 0; g--)
            if (s1_any[g]) nxt_idx = {GSW'(g), s1_idx[g]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_none  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_idx   <= nxt_idx;
            out_none  <= nxt_none;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ONEHOT_CHECK_EN
    logic [NGRP-1:0] grp_multi, s1_multi;

    // v & (v-1) clears the lowest set bit; anything left means two or more bits.
    for (genvar g = 0; g < NGRP; g++) begin : g_multi
        assign grp_multi[g] = |(grp_vec[g] & (grp_vec[g] - 1'b1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        s1_multi <= '0;
        else if (in_xfer) s1_multi <= grp_multi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        out_multi <= 1'b0;
        else if (s2_load) out_multi <= (|s1_multi) || (|(s1_any & (s1_any - 1'b1)));
    end
`else
    assign out_multi = 1'b0;
`endif
endmodule

// File: tb/tb_enc512x9_pipe.sv
// Scoreboard bench for enc512x9_pipe: driver pushes expected results, negedge monitor pops and compares.

module tb_enc512x9_pipe;
    typedef struct packed {
        logic [8:0] idx;
        logic       none;
        logic       multi;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [511:0] in_vec = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [8:0]   out_idx;
    logic         out_none;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_multi;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    logic       hold_vld = 1'b0;
    logic [8:0] hold_idx;
    logic       hold_none, hold_multi;

    enc512x9_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_idx   (out_idx),
        .out_none  (out_none),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_multi (out_multi)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] bits3(input int a, input int b, input int c);
        logic [511:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    function automatic exp_t mk(input int idx, input logic none, input logic multi);
        exp_t e;
        e.idx  = 9'(idx);
        e.none = none;
`ifdef ONEHOT_CHECK_EN
        e.multi = multi;
`else
        e.multi = 1'b0 & multi;
`endif
        return e;
    endfunction

    // Present a vector and wait (bounded) for its input transfer, then record the expected result.
    task automatic send(input logic [511:0] v, input exp_t e);
        int n;
        in_vec   = v;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            fails++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        q.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Monitor: compare every output transfer against the scoreboard; check hold stability under stall.
    always @(negedge clk) begin
        if (reset) begin
            hold_vld <= 1'b0;
        end else begin
            if (hold_vld && out_valid) begin
                checks++;
                if ({out_idx, out_none, out_multi} != {hold_idx, hold_none, hold_multi}) begin
                    fails++;
                    $display("FAIL hold_stable: got %0d/%0b/%0b required %0d/%0b/%0b",
                             out_idx, out_none, out_multi, hold_idx, hold_none, hold_multi);
                end
            end
            hold_vld   <= out_valid && !out_ready;
            hold_idx   <= out_idx;
            hold_none  <= out_none;
            hold_multi <= out_multi;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: idx=%0d with empty scoreboard", out_idx);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (out_idx != e.idx || out_none != e.none || out_multi != e.multi) begin
                        fails++;
                        $display("FAIL result: idx/none/multi got %0d/%0b/%0b required %0d/%0b/%0b",
                                 out_idx, out_none, out_multi, e.idx, e.none, e.multi);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_none", out_none, 0);
        chk("rst_out_multi", out_multi, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);

        // Back-to-back one-hot stream.
        send(bits3(0, -1, -1),   mk(0, 0, 0));
        send(bits3(63, -1, -1),  mk(63, 0, 0));
        send(bits3(64, -1, -1),  mk(64, 0, 0));
        send(bits3(300, -1, -1), mk(300, 0, 0));
        send(bits3(511, -1, -1), mk(511, 0, 0));

        // Priority among multiple bits, and the empty vector.
        send(bits3(5, 200, 511), mk(5, 0, 1));
        send(bits3(130, 400, -1), mk(130, 0, 1));
        send('0, mk(0, 1, 0));
        send(bits3(0, 256, 511), mk(0, 0, 1));
        send(bits3(3, 4, -1), mk(3, 0, 1));
        send(bits3(3, 70, -1), mk(3, 0, 1));
        send(bits3(70, -1, -1), mk(70, 0, 0));
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: fill both stages, third vector must stall.
        out_ready = 1'b0;
        send(bits3(10, -1, -1), mk(10, 0, 0));
        send(bits3(20, -1, -1), mk(20, 0, 0));
        in_vec   = bits3(30, -1, -1);
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_idx", out_idx, 10);
        end
        @(posedge clk); #1;
        in_vec = bits3(31, -1, -1);
        @(posedge clk); #1;
        in_vec = bits3(30, -1, -1);
        out_ready = 1'b1;
        send(bits3(30, -1, -1), mk(30, 0, 0));
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("bp_drained", q.size(), 0);

        // Reset with both stages full: output drops immediately, in-flight data is lost.
        out_ready = 1'b0;
        send(bits3(100, -1, -1), mk(100, 0, 0));
        send(bits3(101, -1, -1), mk(101, 0, 0));
        @(negedge clk);
        chk("full_out_valid", out_valid, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_idx", out_idx, 0);
        q.delete();
        @(posedge clk); #2;
        reset     = 1'b0;
        out_ready = 1'b1;
        send(bits3(77, -1, -1), mk(77, 0, 0));
        @(negedge clk);
        chk("lat_s1_only_out_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_idx", out_idx, 77);

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("final_drained", q.size(), 0);
        chk("final_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
